// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type and word width for the mode-0 SPI responder
package spi_pkg;

    typedef enum logic {SLV_IDLE, SLV_ACTIVE} spi_slave_state_e;

    localparam int SPI_DATA_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with one-cycle rise/fall strobes
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Resetting to 0 means a chip select held low through reset never looks like a new falling edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;
    assign fall = ~sync[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/spi_slave_mode00.sv
// rtl/spi_slave_mode00.sv - SPI mode-0 responder; SPI_SLAVE_BYTE_COUNT_EN adds n_rx_count_o
module spi_slave_mode00
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sclk_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              overrun_o,
    output logic              busy_o
`ifdef SPI_SLAVE_BYTE_COUNT_EN
    ,
    output logic [9:0]        n_rx_count_o
`endif
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

    spi_slave_state_e       state;
    logic [DATA_W-1:0]      tx_sh;
    logic [DATA_W-1:0]      tx_buf;
    logic                   tx_full;
    logic [DATA_W-2:0]      rx_sh;
    logic [CNT_W-1:0]       bit_cnt;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                   byte_done, reload;
    logic [DATA_W-1:0]      reload_val;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din   (sclk_i),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .din   (cs_i),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as the sclk path so MOSI is sampled on the strobe of its own edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) mosi_sync <= '0;
        else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_comb begin
        byte_done  = (state == SLV_ACTIVE) && !cs_rise && sclk_rise && (bit_cnt == LAST_BIT);
        reload     = ((state == SLV_IDLE) && cs_fall) ||
                     ((state == SLV_ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == FULL_CNT));
        reload_val = tx_full ? tx_buf : (tx_valid_i ? tx_data_i : '0);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= SLV_IDLE;
            tx_sh      <= '0;
            tx_buf     <= '0;
            tx_full    <= 1'b0;
            rx_sh      <= '0;
            bit_cnt    <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            // A reload with an empty buffer takes tx_data_i directly, so the buffer stays empty.
            if (reload)
                tx_full <= 1'b0;
            else if (tx_valid_i && !tx_full) begin
                tx_buf  <= tx_data_i;
                tx_full <= 1'b1;
            end

            if (rx_valid_o && rx_ready_i)
                rx_valid_o <= 1'b0;

            case (state)
                SLV_IDLE: begin
                    if (cs_fall) begin
                        state     <= SLV_ACTIVE;
                        tx_sh     <= reload_val;
                        bit_cnt   <= '0;
                        overrun_o <= 1'b0;
                    end
                end
                SLV_ACTIVE: begin
                    if (cs_rise) begin
                        state   <= SLV_IDLE;
                        bit_cnt <= '0;
                        rx_sh   <= '0;
                    end else begin
                        if (sclk_rise) begin
                            rx_sh   <= {rx_sh[DATA_W-3:0], mosi_s};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (byte_done) begin
                            rx_data_o  <= {rx_sh, mosi_s};
                            rx_valid_o <= 1'b1;
                            if (rx_valid_o && !rx_ready_i)
                                overrun_o <= 1'b1;
                        end
                        if (sclk_fall) begin
                            if (bit_cnt == FULL_CNT) begin
                                bit_cnt <= '0;
                                tx_sh   <= reload_val;
                            end else begin
                                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= SLV_IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_BYTE_COUNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            n_rx_count_o <= '0;
        else if ((state == SLV_IDLE) && cs_fall)
            n_rx_count_o <= '0;
        else if (byte_done && (n_rx_count_o != 10'd1023))
            n_rx_count_o <= n_rx_count_o + 10'd1;
    end
`endif

    assign miso_oe_o  = (state == SLV_ACTIVE);
    assign miso_o     = (state == SLV_ACTIVE) ? tx_sh[DATA_W-1] : 1'b0;
    assign busy_o     = (state == SLV_ACTIVE);
    assign tx_ready_o = ~tx_full;

endmodule
